// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the 16-bit mini-CPU.
// It owns the PC, the IR, the halt/illegal flags and the retired-instruction counter.
module cpu_seq_ctrl #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_mode,
  input  logic [15:0]      imem_data,
  input  logic             a_is_zero,
  output logic [PC_W-1:0]  pc,
  output logic [15:0]      ir,
  output logic [3:0]       alu_op,
  output logic [2:0]       rd,
  output logic [2:0]       rs1,
  output logic [2:0]       rs2,
  output logic             rf_we,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_BZ   = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [15:0]      ir_q, ir_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [3:0]       opcode;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  pc_inc;
  logic [CNT_W-1:0] retired_inc;
  state_t           done_state;

  assign opcode      = ir_q[15:12];
  assign target      = ir_q[PC_W-1:0];
  assign pc_inc      = pc_q + PC_W'(1);
  assign retired_inc = retired_q + CNT_W'(1);
  // step_mode only matters on the edge that completes an instruction
  assign done_state  = step_mode ? IDLE : FETCH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    retired_d = retired_q;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        ir_d    = imem_data;
        state_d = DECODE;
      end
      DECODE: begin
        if (opcode <= OP_BZ) begin
          state_d = EXEC;
        end else if (opcode == OP_HALT) begin
          state_d   = HALT;
          halted_d  = 1'b1;
          retired_d = retired_inc;
        end else begin
          // unused opcodes trap without counting as retired
          state_d   = HALT;
          halted_d  = 1'b1;
          illegal_d = 1'b1;
        end
      end
      EXEC: begin
        if (opcode == OP_JMP) begin
          pc_d      = target;
          retired_d = retired_inc;
          state_d   = done_state;
        end else if (opcode == OP_BZ) begin
          pc_d      = a_is_zero ? target : pc_inc;
          retired_d = retired_inc;
          state_d   = done_state;
        end else begin
          state_d = WB;
        end
      end
      WB: begin
        pc_d      = pc_inc;
        retired_d = retired_inc;
        state_d   = done_state;
      end
      HALT: begin
        if (start) begin
          pc_d      = '0;
          halted_d  = 1'b0;
          illegal_d = 1'b0;
          state_d   = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign alu_op  = ir_q[15:12];
  assign rd      = ir_q[11:9];
  assign rs1     = ir_q[8:6];
  assign rs2     = ir_q[5:3];
  assign rf_we   = (state_q == WB);
  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign retired = retired_q;
  assign state   = state_q;

endmodule
